// File: rtl/pipe_stage_chain.sv
// Elastic register chain with per-stage valid bits, collapsing bubbles and per-stage flush.
// Optional saturating stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int CW    = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic [DEPTH-1:0] flush_mask,
  output logic [CW-1:0]    occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  logic [DEPTH-1:0] r;
  logic             ready_acc;

  // A stage may advance when any stage at or beyond it has a hole, or the sink drains.
  always_comb begin
    ready_acc = out_ready;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_acc = ready_acc || !v_q[i];
      r[i] = ready_acc;
    end
  end

  assign in_ready = r[0] && !flush_mask[0];

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (flush_mask[0]) begin
      v_d[0] = 1'b0;
    end else if (r[0]) begin
      v_d[0] = in_valid && in_ready;
      d_d[0] = in_data;
    end
    // Flushing stage i only kills what it would hold next; its outgoing transfer still happens.
    for (int i = 1; i < DEPTH; i++) begin
      if (flush_mask[i]) begin
        v_d[i] = 1'b0;
      end else if (r[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bubble_q, bubble_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (!out_valid && out_ready && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: positional item-queue model plus directed literal checks.
// Counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_chain;

  localparam int W  = 32;
  localparam int D  = 5;
  localparam int CW = 3;

  logic          Clk;
  logic          Reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [D-1:0]  flush_mask;
  logic [CW-1:0] occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush_mask (flush_mask),
    .occupancy  (occupancy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each live item is a (position, data) pair, oldest first.
  typedef struct {
    int          pos;
    logic [31:0] data;
  } item_t;

  item_t       mq[$];
  item_t       nq[$];
  item_t       it;
  logic        m_ir;
  logic        m_ov;
  logic [31:0] m_stall;
  logic [31:0] m_bubble;
  logic [31:0] emitted[$];
  int          n_accepted = 0;

  function automatic logic slot_full(input int p);
    foreach (mq[k]) if (mq[k].pos == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] slot_data(input int p);
    foreach (mq[k]) if (mq[k].pos == p) return mq[k].data;
    return 32'h0;
  endfunction

  // An item is stuck only if everything from it to the output is occupied and the sink is not draining.
  function automatic logic blocked(input int p);
    if (out_ready) return 1'b0;
    for (int q = p; q < D; q++) if (!slot_full(q)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic mdl_in_ready();
    return !flush_mask[0] && !(slot_full(0) && blocked(0));
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      m_stall  = 32'h0;
      m_bubble = 32'h0;
    end else begin
      m_ir = mdl_in_ready();
      m_ov = slot_full(D - 1);
      if (m_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (!m_ov && out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 1;
      nq.delete();
      foreach (mq[k]) begin
        it = mq[k];
        if (it.pos == D - 1 && out_ready) continue;
        if (!blocked(it.pos)) it.pos = it.pos + 1;
        if (!flush_mask[it.pos]) nq.push_back(it);
      end
      if (in_valid && m_ir) nq.push_back('{0, in_data});
      mq = nq;
    end
  end

  // Compare process: outputs against the model every cycle outside reset.
  always @(negedge Clk) begin
    if (!Reset) begin
      checkOutput("out_valid", 64'(out_valid), 64'(slot_full(D - 1)));
      if (slot_full(D - 1)) checkOutput("out_data", 64'(out_data), 64'(slot_data(D - 1)));
      checkOutput("occupancy", 64'(occupancy), 64'(mq.size()));
      checkOutput("in_ready", 64'(in_ready), 64'(mdl_in_ready()));
`ifdef PIPE_PERF_CNT_EN
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
      if (out_valid && out_ready) emitted.push_back(out_data);
      if (in_valid && in_ready) n_accepted++;
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy, input logic [D-1:0] fm);
    in_valid   = v;
    in_data    = d;
    out_ready  = ordy;
    flush_mask = fm;
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush_mask = '0;
    Reset      = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  int          rise;
  int          acc0;
  int          emit0;
  logic [31:0] s0;
  logic [31:0] exp_d;
  logic        rv;
  logic        ro;
  logic [D-1:0] rf;

  initial begin
    Reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush_mask = '0;

    // Reset state
    doReset();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_occupancy", 64'(occupancy), 64'd0);

    // Streaming A0..A9 with the sink always ready
    emitted.delete();
    rise = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b1, '0);
      if (out_valid && rise == 0) rise = i + 1;
    end
    checkOutput("latency", 64'(rise), 64'd5);
    checkOutput("stream_occupancy", 64'(occupancy), 64'd5);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("stream_count", 64'(emitted.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      exp_d = 32'hA0 + 32'(i);
      if (i < emitted.size()) checkOutput("stream_order", 64'(emitted[i]), 64'(exp_d));
    end

    // Fill with the sink stalled
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hC0 + 32'(i), 1'b0, '0);
    in_valid = 1'b1;
    in_data  = 32'hC5;
    #1;
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_occupancy", 64'(occupancy), 64'd5);
    checkOutput("full_out_data", 64'(out_data), 64'hC0);
`ifdef PIPE_PERF_CNT_EN
    s0 = stall_cnt;
`endif
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC5, 1'b0, '0);
    checkOutput("frozen_occupancy", 64'(occupancy), 64'd5);
    checkOutput("frozen_out_data", 64'(out_data), 64'hC0);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("stall_delta", 64'(stall_cnt - s0), 64'd3);
`endif

    // Gap between first and second item collapses while stalled
    doReset();
    applyStimulus(1'b1, 32'hD1, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'hD2, 1'b0, '0);
    applyStimulus(1'b1, 32'hD3, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("gap_occupancy", 64'(occupancy), 64'd3);
    checkOutput("gap_valid_bits", 64'(dut.v_q), 64'b11100);
    checkOutput("gap_out_data", 64'(out_data), 64'hD1);
    emitted.delete();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("gap_drain_count", 64'(emitted.size()), 64'd3);
    if (emitted.size() == 3) begin
      checkOutput("gap_drain_0", 64'(emitted[0]), 64'hD1);
      checkOutput("gap_drain_1", 64'(emitted[1]), 64'hD2);
      checkOutput("gap_drain_2", 64'(emitted[2]), 64'hD3);
    end

    // Flush stages 1 and 2 of a full chain
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hB1 + 32'(i), 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 5'b00110);
    checkOutput("flush_occupancy", 64'(occupancy), 64'd3);
    checkOutput("flush_valid_bits", 64'(dut.v_q), 64'b11001);
    emitted.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("flush_drain_count", 64'(emitted.size()), 64'd3);
    if (emitted.size() == 3) begin
      checkOutput("flush_drain_0", 64'(emitted[0]), 64'hB1);
      checkOutput("flush_drain_1", 64'(emitted[1]), 64'hB2);
      checkOutput("flush_drain_2", 64'(emitted[2]), 64'hB5);
    end

    // Asynchronous reset in the middle of a clock period
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hE0 + 32'(i), 1'b0, '0);
    checkOutput("pre_reset_occupancy", 64'(occupancy), 64'd4);
    in_valid = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_occupancy", 64'(occupancy), 64'd0);
    checkOutput("async_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("async_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("async_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    #1;
    Reset = 1'b0;
    applyStimulus(1'b1, 32'hEE, 1'b1, '0);
    checkOutput("resume_occupancy", 64'(occupancy), 64'd1);

    // Full chain at full throughput for 20 cycles
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hF0 + 32'(i), 1'b0, '0);
    acc0  = n_accepted;
    emit0 = emitted.size();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, '0);
      checkOutput("tput_occupancy", 64'(occupancy), 64'd5);
    end
    checkOutput("tput_in", 64'(n_accepted - acc0), 64'd20);
    checkOutput("tput_out", 64'(emitted.size() - emit0), 64'd20);

    // Randomized traffic with occasional flushes, checked by the model every cycle
    doReset();
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ro = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 11) == 0) ? D'($urandom) : '0;
      applyStimulus(rv, $urandom, ro, rf);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("random_drained", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
